// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// A flush or a load-use hazard loads a bubble; otherwise the ID fields are copied forward.
module id_ex_stage #(
  parameter logic [15:0] STALL_MAX = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        Valid_ID,
  input  logic [31:0] PC_ID,
  input  logic [31:0] RD1_ID,
  input  logic [31:0] RD2_ID,
  input  logic [31:0] Imm_ID,
  input  logic [4:0]  Rs1_ID,
  input  logic [4:0]  Rs2_ID,
  input  logic [4:0]  Rd_ID,
  input  logic        RegWrite_ID,
  input  logic        MemRead_ID,
  input  logic        MemWrite_ID,
  input  logic        MemtoReg_ID,
  input  logic        ALUSrc_ID,
  input  logic        Branch_ID,
  input  logic [3:0]  ALUOp_ID,
  input  logic        Flush_EX,
  output logic [31:0] PC_EX,
  output logic [31:0] RD1_EX,
  output logic [31:0] RD2_EX,
  output logic [31:0] Imm_EX,
  output logic [4:0]  Rs1_EX,
  output logic [4:0]  Rs2_EX,
  output logic [4:0]  Rd_EX,
  output logic        RegWrite_EX,
  output logic        MemRead_EX,
  output logic        MemWrite_EX,
  output logic        MemtoReg_EX,
  output logic        ALUSrc_EX,
  output logic        Branch_EX,
  output logic [3:0]  ALUOp_EX,
  output logic        Valid_EX,
  output logic        Stall,
  output logic [15:0] StallCount
);

  logic load_use;
  logic bubble;

  // Rs2 is compared even for formats without rs2; a spurious stall is harmless.
  assign load_use = Valid_EX & MemRead_EX & Valid_ID & (Rd_EX != 5'd0) &
                    ((Rd_EX == Rs1_ID) | (Rd_EX == Rs2_ID));
  assign Stall    = load_use & ~Flush_EX;
  assign bubble   = Flush_EX | load_use;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Valid_EX    <= 1'b0;
      PC_EX       <= 32'd0;
      RD1_EX      <= 32'd0;
      RD2_EX      <= 32'd0;
      Imm_EX      <= 32'd0;
      Rs1_EX      <= 5'd0;
      Rs2_EX      <= 5'd0;
      Rd_EX       <= 5'd0;
      RegWrite_EX <= 1'b0;
      MemRead_EX  <= 1'b0;
      MemWrite_EX <= 1'b0;
      MemtoReg_EX <= 1'b0;
      ALUSrc_EX   <= 1'b0;
      Branch_EX   <= 1'b0;
      ALUOp_EX    <= 4'd0;
    end else if (bubble) begin
      // Indices are cleared too so forwarding can never match a bubble.
      Valid_EX    <= 1'b0;
      PC_EX       <= 32'd0;
      RD1_EX      <= 32'd0;
      RD2_EX      <= 32'd0;
      Imm_EX      <= 32'd0;
      Rs1_EX      <= 5'd0;
      Rs2_EX      <= 5'd0;
      Rd_EX       <= 5'd0;
      RegWrite_EX <= 1'b0;
      MemRead_EX  <= 1'b0;
      MemWrite_EX <= 1'b0;
      MemtoReg_EX <= 1'b0;
      ALUSrc_EX   <= 1'b0;
      Branch_EX   <= 1'b0;
      ALUOp_EX    <= 4'd0;
    end else begin
      Valid_EX    <= Valid_ID;
      PC_EX       <= PC_ID;
      RD1_EX      <= RD1_ID;
      RD2_EX      <= RD2_ID;
      Imm_EX      <= Imm_ID;
      Rs1_EX      <= Rs1_ID;
      Rs2_EX      <= Rs2_ID;
      Rd_EX       <= Rd_ID;
      RegWrite_EX <= RegWrite_ID & Valid_ID;
      MemRead_EX  <= MemRead_ID  & Valid_ID;
      MemWrite_EX <= MemWrite_ID & Valid_ID;
      MemtoReg_EX <= MemtoReg_ID & Valid_ID;
      ALUSrc_EX   <= ALUSrc_ID   & Valid_ID;
      Branch_EX   <= Branch_ID   & Valid_ID;
      ALUOp_EX    <= ALUOp_ID    & {4{Valid_ID}};
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      StallCount <= 16'd0;
    end else if (Stall && (StallCount != STALL_MAX)) begin
      StallCount <= StallCount + 16'd1;
    end
  end

endmodule
